// File: rtl/store_align_unit.sv
// Store-side byte-lane packer: narrows a store operand to byte/half/word lanes with
// byte enables, buffered in a 2-entry elastic FIFO; misaligned/reserved stores are dropped.
module store_align_unit #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic [3:0]       out_be,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [31:0]      addr_q [2];
  logic [31:0]      data_q [2];
  logic [3:0]       be_q   [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             err_valid_q;
  logic [31:0]      err_addr_q;
  logic [ERR_W-1:0] err_count_q;

  logic             legal;
  logic [3:0]       pk_be;
  logic [31:0]      pk_data;
  logic             accept, enq, deq;

  // Handshake: a transfer happens on a side when its valid and ready are both high
  // at the rising edge; in_ready depends only on the registered count.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign enq       = accept && legal;
  assign deq       = out_valid && out_ready;

  always_comb begin
    legal   = 1'b0;
    pk_be   = 4'b0000;
    pk_data = 32'h0;
    unique case (in_size)
      2'b00: begin
        legal   = 1'b1;
        pk_be   = 4'b0001 << in_addr[1:0];
        pk_data = {4{in_data[7:0]}};
      end
      2'b01: begin
        legal   = !in_addr[0];
        pk_be   = in_addr[1] ? 4'b1100 : 4'b0011;
        pk_data = {2{in_data[15:0]}};
      end
      2'b10: begin
        legal   = (in_addr[1:0] == 2'b00);
        pk_be   = 4'b1111;
        pk_data = in_data;
      end
      default: begin
        legal   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = enq ? !wr_ptr_q : wr_ptr_q;
    rd_ptr_d = deq ? !rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq)      count_d = count_q + 2'd1;
    else if (!enq && deq) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
        be_q[i]   <= 4'h0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0;
      err_count_q <= '0;
    end else begin
      if (enq) begin
        addr_q[wr_ptr_q] <= {in_addr[31:2], 2'b00};
        data_q[wr_ptr_q] <= pk_data;
        be_q[wr_ptr_q]   <= pk_be;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= accept && !legal;
      if (accept && !legal) begin
        err_addr_q <= in_addr;
        if (err_count_q != ERR_MAX) err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  // Outputs are forced to zero when empty so no stale enables reach memory.
  assign out_addr  = out_valid ? addr_q[rd_ptr_q] : 32'h0;
  assign out_data  = out_valid ? data_q[rd_ptr_q] : 32'h0;
  assign out_be    = out_valid ? be_q[rd_ptr_q]   : 4'h0;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane packing, error path, back-pressure,
// saturation and asynchronous reset.
module tb_store_align_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  store_align_unit #(.DEPTH(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_be !== 4'h0 ||
        out_addr !== 32'h0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_out: valid=%b ready=%b be=%h addr=%h data=%h, need 0 1 0 0 0",
               out_valid, in_ready, out_be, out_addr, out_data);
    end
    checks++;
    if (err_valid !== 1'b0 || err_addr !== 32'h0 || err_count !== 8'h0) begin
      failures++;
      $display("FAIL reset_err: ev=%b ea=%h ec=%0d, need 0 0 0", err_valid, err_addr, err_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_lanes();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h12345678, 2'b00);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL sb_ready[%0d]: in_ready=%b, need 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_be !== (4'b0001 << i) ||
          out_data !== 32'h78787878 || out_addr !== 32'h100) begin
        failures++;
        $display("FAIL sb_lane[%0d]: v=%b be=%b data=%h addr=%h, need 1 %b 78787878 00000100",
                 i, out_valid, out_be, out_data, out_addr, 4'b0001 << i);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_be !== 4'h0) begin
      failures++;
      $display("FAIL sb_drain: v=%b be=%b, need 0 0000", out_valid, out_be);
    end
  endtask

  task automatic test_half_word();
    out_ready = 1'b1;
    drive(1'b1, 32'h202, 32'hAABBCCDD, 2'b01);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_be !== 4'b1100 || out_data !== 32'hCCDDCCDD ||
        out_addr !== 32'h200) begin
      failures++;
      $display("FAIL sh_202: v=%b be=%b data=%h addr=%h, need 1 1100 ccddccdd 00000200",
               out_valid, out_be, out_data, out_addr);
    end
    drive(1'b1, 32'h204, 32'hAABBCCDD, 2'b10);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_be !== 4'b1111 || out_data !== 32'hAABBCCDD ||
        out_addr !== 32'h204) begin
      failures++;
      $display("FAIL sw_204: v=%b be=%b data=%h addr=%h, need 1 1111 aabbccdd 00000204",
               out_valid, out_be, out_data, out_addr);
    end
    drive(1'b1, 32'h20C, 32'h00005A5A, 2'b01);
    tick();
    checks++;
    if (out_be !== 4'b0011 || out_data !== 32'h5A5A5A5A || out_addr !== 32'h20C) begin
      failures++;
      $display("FAIL sh_20c: be=%b data=%h addr=%h, need 0011 5a5a5a5a 0000020c",
               out_be, out_data, out_addr);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h301; sizes[0] = 2'b01;
    addrs[1] = 32'h302; sizes[1] = 2'b10;
    addrs[2] = 32'h30C; sizes[2] = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addrs[i], 32'hDEADBEEF, sizes[i]);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mis_ready[%0d]: in_ready=%b, need 1", i, in_ready);
      end
      tick();
      checks++;
      if (err_valid !== 1'b1 || err_addr !== addrs[i] || out_valid !== 1'b0 ||
          err_count !== 8'(i + 1)) begin
        failures++;
        $display("FAIL mis_err[%0d]: ev=%b ea=%h ov=%b ec=%0d, need 1 %h 0 %0d",
                 i, err_valid, err_addr, out_valid, err_count, addrs[i], i + 1);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    checks++;
    if (err_valid !== 1'b0 || err_count !== 8'd3 || err_addr !== 32'h30C) begin
      failures++;
      $display("FAIL mis_idle: ev=%b ec=%0d ea=%h, need 0 3 0000030c",
               err_valid, err_count, err_addr);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h401, 32'h00000011, 2'b00);
    tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: v=%b in_ready=%b, need 1 1", out_valid, in_ready);
    end
    drive(1'b1, 32'h402, 32'h00000022, 2'b00);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b, need 0", in_ready);
    end
    drive(1'b1, 32'h403, 32'h00000033, 2'b00);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_be !== 4'b0010 || out_data !== 32'h11111111 ||
        out_addr !== 32'h400) begin
      failures++;
      $display("FAIL bp_stall: ready=%b be=%b data=%h addr=%h, need 0 0010 11111111 00000400",
               in_ready, out_be, out_data, out_addr);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_comb: in_ready=%b after out_ready rise, need 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_be !== 4'b0100 || out_data !== 32'h22222222) begin
      failures++;
      $display("FAIL bp_second: ready=%b be=%b data=%h, need 1 0100 22222222",
               in_ready, out_be, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_be !== 4'b1000 || out_data !== 32'h33333333) begin
      failures++;
      $display("FAIL bp_third: v=%b be=%b data=%h, need 1 1000 33333333",
               out_valid, out_be, out_data);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_be !== 4'h0) begin
      failures++;
      $display("FAIL bp_empty: v=%b be=%b, need 0 0000", out_valid, out_be);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 32'h0, 2'b11);
      tick();
    end
    checks++;
    if (err_count !== 8'd255 || err_valid !== 1'b1 || err_addr !== 32'h1103) begin
      failures++;
      $display("FAIL sat_count: ec=%0d ev=%b ea=%h, need 255 1 00001103",
               err_count, err_valid, err_addr);
    end
    drive(1'b1, 32'h2002, 32'h0, 2'b10);
    tick();
    checks++;
    if (err_count !== 8'd255 || err_addr !== 32'h2002 || err_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold: ec=%0d ea=%h ev=%b, need 255 00002002 1",
               err_count, err_addr, err_valid);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    checks++;
    if (err_valid !== 1'b0 || err_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_idle: ev=%b ec=%0d, need 0 255", err_valid, err_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h000000AB, 2'b00);
    tick();
    drive(1'b1, 32'h504, 32'h000000CD, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_full: ready=%b v=%b, need 0 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_be !== 4'h0 || in_ready !== 1'b1 || err_count !== 8'h0) begin
      failures++;
      $display("FAIL rst_async: v=%b be=%b ready=%b ec=%0d, need 0 0000 1 0",
               out_valid, out_be, in_ready, err_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: ready=%b v=%b, need 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h602, 32'h0000BEEF, 2'b01);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_be !== 4'b1100 || out_data !== 32'hBEEFBEEF ||
        out_addr !== 32'h600) begin
      failures++;
      $display("FAIL rst_after: v=%b be=%b data=%h addr=%h, need 1 1100 beefbeef 00000600",
               out_valid, out_be, out_data, out_addr);
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_half_word();
    test_misaligned();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
